acq_sequencer: RTL

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

---
 rtl/acq_pkg.sv | 14 +
 rtl/acq_accum.sv | 59 +++++
 rtl/acq_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer and its accumulator.
package acq_pkg;

    localparam int SAMPLE_W         = 12;
    localparam int SAMPLES_LOG2_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_ACQ,
        ST_HOLD
    } acq_state_t;

endpackage

// File: rtl/acq_accum.sv
// Sample accumulator: new_data edge detect, two channel sums, sample counter
// and the truncating average shift. Clear always wins over accumulation.
module acq_accum
    import acq_pkg::*;
#(
    parameter int SAMPLES_LOG2 = SAMPLES_LOG2_DEF
) (
    input  logic                clk_20M,
    input  logic                reset_n,
    input  logic                acq_en,
    input  logic                clear,
    input  logic                new_data,
    input  logic [SAMPLE_W-1:0] pdata1,
    input  logic [SAMPLE_W-1:0] pdata2,
    output logic                will_complete,
    output logic                frame_full,
    output logic [SAMPLE_W-1:0] avg1,
    output logic [SAMPLE_W-1:0] avg2
);

    localparam int SUM_W = SAMPLE_W + SAMPLES_LOG2;
    localparam int CNT_W = SAMPLES_LOG2 + 1;

    logic             nd_q;
    logic             sample_edge;
    logic [SUM_W-1:0] sum1;
    logic [SUM_W-1:0] sum2;
    logic [CNT_W-1:0] cnt;

    assign sample_edge   = new_data & ~nd_q;
    // The edge being taken this cycle is the last one of the frame.
    assign will_complete = acq_en && sample_edge &&
                           (cnt == CNT_W'((1 << SAMPLES_LOG2) - 1));
    assign frame_full    = cnt[SAMPLES_LOG2];
    assign avg1          = sum1[SUM_W-1:SAMPLES_LOG2];
    assign avg2          = sum2[SUM_W-1:SAMPLES_LOG2];

    // Edge register, running sums and sample count.
    always_ff @(posedge clk_20M) begin
        if (!reset_n) begin
            nd_q <= 1'b0;
            sum1 <= '0;
            sum2 <= '0;
            cnt  <= '0;
        end else begin
            nd_q <= new_data;
            if (clear) begin
                sum1 <= '0;
                sum2 <= '0;
                cnt  <= '0;
            end else if (acq_en && sample_edge) begin
                sum1 <= sum1 + SUM_W'(pdata1);
                sum2 <= sum2 + SUM_W'(pdata2);
                cnt  <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms the ADC window, averages one frame of samples,
// hands the averages to a consumer and repeats for the requested frame count.
//
//  state | meaning
//  IDLE  | waiting for start
//  ARM   | sample_control high, waiting for the window to open (bounded)
//  ACQ   | accumulating samples on new_data rising edges
//  HOLD  | averages presented, waiting for avg_ready
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int SAMPLES_LOG2 = SAMPLES_LOG2_DEF,
    parameter int ARM_TIMEOUT  = 4095
) (
    input  logic                clk_20M,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          frame_count,
    input  logic                new_data,
    input  logic [SAMPLE_W-1:0] pdata1,
    input  logic [SAMPLE_W-1:0] pdata2,
    input  logic                window_done,
    output logic                sample_control,
    output logic                busy,
    output logic [SAMPLE_W-1:0] avg1,
    output logic [SAMPLE_W-1:0] avg2,
    output logic                avg_valid,
    input  logic                avg_ready,
    output logic [7:0]          frames_done,
    output logic                err_timeout,
    output logic                err_short
);

    localparam int TMR_W = $clog2(ARM_TIMEOUT + 1);

    acq_state_t          state;
    logic [7:0]          fc_q;
    logic [TMR_W-1:0]    arm_tmr;
    logic                wd_q;
    logic                wd_rise;
    logic                short_hit;
    logic                acc_clear;
    logic                will_complete;
    logic                frame_full;
    logic [SAMPLE_W-1:0] acc_avg1;
    logic [SAMPLE_W-1:0] acc_avg2;

    assign busy    = (state != ST_IDLE);
    assign wd_rise = window_done & ~wd_q;
    // A coincident last sample or an already full frame beats the early close.
    assign short_hit = (state == ST_ACQ) && wd_rise && !will_complete && !frame_full;

    // Sums only exist inside ACQ; drop them on any way out of it.
    always_comb begin
        acc_clear = 1'b0;
        if (abort || (state != ST_ACQ) || frame_full || short_hit) begin
            acc_clear = 1'b1;
        end
    end

    acq_accum #(
        .SAMPLES_LOG2 (SAMPLES_LOG2)
    ) u_accum (
        .clk_20M       (clk_20M),
        .reset_n       (reset_n),
        .acq_en        (state == ST_ACQ),
        .clear         (acc_clear),
        .new_data      (new_data),
        .pdata1        (pdata1),
        .pdata2        (pdata2),
        .will_complete (will_complete),
        .frame_full    (frame_full),
        .avg1          (acc_avg1),
        .avg2          (acc_avg2)
    );

    // Sequencer FSM with registered outputs and the ARM down-counter.
    always_ff @(posedge clk_20M) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            fc_q           <= '0;
            arm_tmr        <= '0;
            wd_q           <= 1'b0;
            sample_control <= 1'b0;
            avg_valid      <= 1'b0;
            avg1           <= '0;
            avg2           <= '0;
            frames_done    <= '0;
            err_timeout    <= 1'b0;
            err_short      <= 1'b0;
        end else begin
            wd_q <= window_done;
            if (abort) begin
                state          <= ST_IDLE;
                sample_control <= 1'b0;
                avg_valid      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            fc_q           <= frame_count;
                            frames_done    <= '0;
                            err_timeout    <= 1'b0;
                            err_short      <= 1'b0;
                            arm_tmr        <= TMR_W'(ARM_TIMEOUT);
                            sample_control <= 1'b1;
                            state          <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        if (!window_done) begin
                            sample_control <= 1'b0;
                            state          <= ST_ACQ;
                        end else if (arm_tmr == '0) begin
                            err_timeout    <= 1'b1;
                            sample_control <= 1'b0;
                            state          <= ST_IDLE;
                        end else begin
                            arm_tmr <= arm_tmr - TMR_W'(1);
                        end
                    end
                    ST_ACQ: begin
                        if (frame_full) begin
                            avg1        <= acc_avg1;
                            avg2        <= acc_avg2;
                            avg_valid   <= 1'b1;
                            frames_done <= frames_done + 8'd1;
                            state       <= ST_HOLD;
                        end else if (short_hit) begin
                            err_short      <= 1'b1;
                            arm_tmr        <= TMR_W'(ARM_TIMEOUT);
                            sample_control <= 1'b1;
                            state          <= ST_ARM;
                        end
                    end
                    ST_HOLD: begin
                        if (avg_ready) begin
                            avg_valid <= 1'b0;
                            if ((fc_q == 8'd0) || (frames_done < fc_q)) begin
                                arm_tmr        <= TMR_W'(ARM_TIMEOUT);
                                sample_control <= 1'b1;
                                state          <= ST_ARM;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
